// File: rtl/writeback_buffer.sv
// writeback_buffer: two-entry in-order buffer between the execute stage and
// the register-file write port.
// Results are accepted from execute and retired to the register file one per
// cycle. A result aimed at register zero is consumed and dropped.
// Optional feature macro: WB_FORWARD_EN. When it is defined, both read-port
// lookups can see pending values in the buffer. When it is undefined, the
// hit and forward outputs are tied to zero.
module writeback_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValid,
  input  logic [ADDR_WIDTH-1:0] iAddr,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic                  oReady,
  input  logic                  iHold,
  output logic [ADDR_WIDTH-1:0] oAddrWrite,
  output logic [DATA_WIDTH-1:0] oDataWrite,
  output logic                  oEnWrite,
  input  logic [ADDR_WIDTH-1:0] iAddrLook0,
  input  logic [ADDR_WIDTH-1:0] iAddrLook1,
  output logic                  oHit0,
  output logic                  oHit1,
  output logic [DATA_WIDTH-1:0] oFwdData0,
  output logic [DATA_WIDTH-1:0] oFwdData1
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  // The head entry always sits in headQ. The younger entry, if there is
  // one, sits in tailQ. Occupancy is held in countQ, so each entry's valid
  // bit is derived from countQ and reset together with it.
  entry_t     headQ;
  entry_t     tailQ;
  logic [1:0] countQ;

  logic   headValid;
  logic   tailValid;
  logic   accept;
  logic   store;
  logic   retire;
  entry_t newEntry;

  assign headValid = (countQ != 2'd0);
  assign tailValid = (countQ == 2'd2);
  assign newEntry  = '{addr: iAddr, data: iData};

  // oReady depends only on the count register and the reset input. It does
  // not depend on iValid or iHold.
  assign oReady = !iRst && !tailValid;
  assign accept = iValid && oReady;
  assign store  = accept && (iAddr != '0);
  assign retire = headValid && !iHold;

  assign oEnWrite   = headValid;
  assign oAddrWrite = headValid ? headQ.addr : '0;
  assign oDataWrite = headValid ? headQ.data : '0;

  // Occupancy: +1 on a stored enqueue, -1 on a retire, unchanged when both
  // happen or when neither happens.
  // NOTE: sequential state uses non-blocking assignments so that every
  // always_ff block sees the values from before the edge.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      countQ <= 2'd0;
    end else begin
      unique case ({store, retire})
        2'b10:   countQ <= countQ + 2'd1;
        2'b01:   countQ <= countQ - 2'd1;
        default: countQ <= countQ;
      endcase
    end
  end

  // Entry storage. New data goes to the head slot if that slot is free or is
  // being vacated; otherwise it goes to the tail slot. On a retire, the tail
  // slot shifts forward into the head slot.
  // NOTE: the payload registers have no reset. Their contents are ignored
  // whenever countQ marks them empty, so resetting them would only add reset
  // fan-out.
  always_ff @(posedge iClk) begin
    if (store && (!headValid || (countQ == 2'd1 && retire))) begin
      headQ <= newEntry;
    end else if (retire) begin
      headQ <= tailQ;
    end
    if (store && countQ == 2'd1 && !retire) begin
      tailQ <= newEntry;
    end
  end

`ifdef WB_FORWARD_EN
  // Returns {hit, data} for a single lookup. When both entries match, the
  // tail (the younger entry) wins. Register zero never hits.
  function automatic logic [DATA_WIDTH:0] lookup(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  hValid,
    input entry_t                hEntry,
    input logic                  tValid,
    input entry_t                tEntry
  );
    lookup = '0;
    if (addr != '0) begin
      if (tValid && tEntry.addr == addr) begin
        lookup = {1'b1, tEntry.data};
      end else if (hValid && hEntry.addr == addr) begin
        lookup = {1'b1, hEntry.data};
      end
    end
  endfunction

  // Lookups read only the current contents. A result enqueued this cycle is
  // not visible yet. The head being retired this cycle is still visible.
  assign {oHit0, oFwdData0} = lookup(iAddrLook0, headValid, headQ, tailValid, tailQ);
  assign {oHit1, oFwdData1} = lookup(iAddrLook1, headValid, headQ, tailValid, tailQ);
`else
  // Forwarding is disabled. The lookup ports are kept but have no effect.
  logic unusedLook;
  assign unusedLook = ^{iAddrLook0, iAddrLook1};
  assign oHit0      = 1'b0;
  assign oHit1      = 1'b0;
  assign oFwdData0  = '0;
  assign oFwdData1  = '0;
`endif

endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: directed vectors and hand-written sequences for
// writeback_buffer. Expected values are hand-computed. When WB_FORWARD_EN is
// undefined, the expected forwarding outputs become zero.
module tb_writeback_buffer;

`ifdef WB_FORWARD_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif

  logic        iClk;
  logic        iRst;
  logic        iValid;
  logic [4:0]  iAddr;
  logic [31:0] iData;
  logic        oReady;
  logic        iHold;
  logic [4:0]  oAddrWrite;
  logic [31:0] oDataWrite;
  logic        oEnWrite;
  logic [4:0]  iAddrLook0;
  logic [4:0]  iAddrLook1;
  logic        oHit0;
  logic        oHit1;
  logic [31:0] oFwdData0;
  logic [31:0] oFwdData1;

  writeback_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iValid     (iValid),
    .iAddr      (iAddr),
    .iData      (iData),
    .oReady     (oReady),
    .iHold      (iHold),
    .oAddrWrite (oAddrWrite),
    .oDataWrite (oDataWrite),
    .oEnWrite   (oEnWrite),
    .iAddrLook0 (iAddrLook0),
    .iAddrLook1 (iAddrLook1),
    .oHit0      (oHit0),
    .oHit1      (oHit1),
    .oFwdData0  (oFwdData0),
    .oFwdData1  (oFwdData1)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  typedef struct {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        hold;
    logic [4:0]  look0;
    logic [4:0]  look1;
    logic        expReady;
    logic        expEn;
    logic [4:0]  expAddrW;
    logic [31:0] expDataW;
    logic        expHit0;
    logic [31:0] expFwd0;
    logic        expHit1;
    logic [31:0] expFwd1;
  } vec_t;

  localparam int NumVecs = 13;
  vec_t vecs[NumVecs];

  int passCount  = 0;
  int totalCount = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic valid, input logic [4:0] addr, input logic [31:0] data,
                       input logic hold, input logic [4:0] look0, input logic [4:0] look1);
    iValid     = valid;
    iAddr      = addr;
    iData      = data;
    iHold      = hold;
    iAddrLook0 = look0;
    iAddrLook1 = look1;
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [31:0] fwd(input logic [31:0] v);
    return FwdOn ? v : 32'd0;
  endfunction

  initial begin
    // Columns: valid addr data hold look0 look1 | ready en addrW dataW hit0 fwd0 hit1 fwd1.
    // A single push with no hold: it appears on the write port one cycle later.
    vecs[0]  = '{1, 3, 32'hDEADBEEF, 0, 3, 0, 1, 1, 3, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0};
    vecs[1]  = '{0, 0, 32'h0,        0, 3, 0, 1, 0, 0, 32'h0,        0, 0,            0, 0};
    // A push to register zero is consumed but not stored.
    vecs[2]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 32'h0,        0, 0,            0, 0};
    // Fill while held; the third push is ignored; then drain 1 and 2 in order.
    vecs[3]  = '{1, 1, 32'h11,       1, 1, 2, 1, 1, 1, 32'h11,       1, 32'h11,       0, 0};
    vecs[4]  = '{1, 2, 32'h22,       1, 1, 2, 0, 1, 1, 32'h11,       1, 32'h11,       1, 32'h22};
    vecs[5]  = '{1, 9, 32'h99,       1, 1, 9, 0, 1, 1, 32'h11,       1, 32'h11,       0, 0};
    vecs[6]  = '{0, 0, 32'h0,        0, 1, 2, 1, 1, 2, 32'h22,       0, 0,            1, 32'h22};
    vecs[7]  = '{0, 0, 32'h0,        0, 1, 2, 1, 0, 0, 32'h0,        0, 0,            0, 0};
    // Same address twice: the youngest value is forwarded.
    vecs[8]  = '{1, 5, 32'hA,        1, 5, 0, 1, 1, 5, 32'hA,        1, 32'hA,        0, 0};
    vecs[9]  = '{1, 5, 32'hB,        1, 5, 0, 0, 1, 5, 32'hA,        1, 32'hB,        0, 0};
    vecs[10] = '{0, 0, 32'h0,        0, 5, 0, 1, 1, 5, 32'hB,        1, 32'hB,        0, 0};
    // Enqueue and retire in the same cycle with count = 1: the count stays 1.
    vecs[11] = '{1, 7, 32'h77,       0, 5, 7, 1, 1, 7, 32'h77,       0, 0,            1, 32'h77};
    vecs[12] = '{0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 32'h0,        0, 0,            0, 0};

    drive(0, 0, 0, 0, 0, 0);
    iRst = 1'b1;
    repeat (2) tick();
    check("rst.ready",  {31'd0, oReady},   32'd0);
    check("rst.en",     {31'd0, oEnWrite}, 32'd0);
    check("rst.addrW",  {27'd0, oAddrWrite}, 32'd0);
    check("rst.dataW",  oDataWrite,        32'd0);
    check("rst.hit0",   {31'd0, oHit0},    32'd0);
    check("rst.fwd0",   oFwdData0,         32'd0);
    iRst = 1'b0;
    #1;
    check("rst.readyAfter", {31'd0, oReady}, 32'd1);

    for (int i = 0; i < NumVecs; i++) begin
      drive(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].hold, vecs[i].look0, vecs[i].look1);
      tick();
      check($sformatf("v%0d.ready", i), {31'd0, oReady},     {31'd0, vecs[i].expReady});
      check($sformatf("v%0d.en", i),    {31'd0, oEnWrite},   {31'd0, vecs[i].expEn});
      check($sformatf("v%0d.addrW", i), {27'd0, oAddrWrite}, {27'd0, vecs[i].expAddrW});
      check($sformatf("v%0d.dataW", i), oDataWrite,          vecs[i].expDataW);
      check($sformatf("v%0d.hit0", i),  {31'd0, oHit0},      fwd({31'd0, vecs[i].expHit0}));
      check($sformatf("v%0d.fwd0", i),  oFwdData0,           fwd(vecs[i].expFwd0));
      check($sformatf("v%0d.hit1", i),  {31'd0, oHit1},      fwd({31'd0, vecs[i].expHit1}));
      check($sformatf("v%0d.fwd1", i),  oFwdData1,           fwd(vecs[i].expFwd1));
    end

    // The head being retired is still visible to lookups in its last cycle;
    // an entry enqueued in the same cycle is not visible yet.
    drive(1, 4, 32'h44, 0, 0, 0);
    tick();
    check("fw.en", {31'd0, oEnWrite}, 32'd1);
    drive(1, 6, 32'h66, 0, 4, 6);
    #1;
    check("fw.retHit0",  {31'd0, oHit0}, fwd(32'd1));
    check("fw.retFwd0",  oFwdData0,      fwd(32'h44));
    check("fw.newHit1",  {31'd0, oHit1}, 32'd0);
    check("fw.newFwd1",  oFwdData1,      32'd0);
    tick();
    check("fw.addrW",    {27'd0, oAddrWrite}, 32'd6);
    check("fw.dataW",    oDataWrite,          32'h66);
    check("fw.goneHit0", {31'd0, oHit0},      32'd0);
    check("fw.hit1",     {31'd0, oHit1},      fwd(32'd1));
    check("fw.fwd1",     oFwdData1,           fwd(32'h66));
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("fw.drained", {31'd0, oEnWrite}, 32'd0);

    // Reset in the middle of a cycle with count = 2: the entries are
    // discarded immediately and nothing is written afterwards.
    drive(1, 1, 32'h11, 1, 1, 0);
    tick();
    drive(1, 2, 32'h22, 1, 1, 0);
    tick();
    check("mr.full.ready", {31'd0, oReady},   32'd0);
    check("mr.full.en",    {31'd0, oEnWrite}, 32'd1);
    #2;
    iRst = 1'b1;
    #1;
    check("mr.en",    {31'd0, oEnWrite},   32'd0);
    check("mr.addrW", {27'd0, oAddrWrite}, 32'd0);
    check("mr.dataW", oDataWrite,          32'd0);
    check("mr.ready", {31'd0, oReady},     32'd0);
    check("mr.hit0",  {31'd0, oHit0},      32'd0);
    drive(1, 3, 32'h33, 0, 3, 0);
    repeat (2) tick();
    check("mr.heldEn",    {31'd0, oEnWrite}, 32'd0);
    check("mr.heldReady", {31'd0, oReady},   32'd0);
    drive(0, 0, 0, 0, 0, 0);
    iRst = 1'b0;
    #1;
    check("mr.readyAfter", {31'd0, oReady}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mr.noWrite%0d", i), {31'd0, oEnWrite}, 32'd0);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of writeback data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, width of register addresses.
REQ-003 SHALL have iClk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have iRst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have iValid  input  1  execute stage presents a result.
REQ-006 SHALL have iAddr  input  ADDR_WIDTH  destination register of presented result.
REQ-007 SHALL have iData  input  DATA_WIDTH  presented result value.
REQ-008 SHALL have oReady  output  1  buffer can accept a result this cycle.
REQ-009 SHALL have iHold  input  1  register-file write port unavailable; retire blocked.
REQ-010 SHALL have oAddrWrite  output  ADDR_WIDTH  register-file write address.
REQ-011 SHALL have oDataWrite  output  DATA_WIDTH  register-file write data.
REQ-012 SHALL have oEnWrite  output  1  register-file write enable.
REQ-013 SHALL have iAddrLook0 and iAddrLook1  input  ADDR_WIDTH  forwarding lookup addresses, matching the two register-file read ports.
REQ-014 SHALL have oHit0 and oHit1  output  1  lookup address is pending in the buffer.
REQ-015 SHALL have oFwdData0 and oFwdData1  output  DATA_WIDTH  forwarded pending value.

Function
REQ-016 SHALL be a 2-entry in-order FIFO of {addr, data} entries with occupancy count 0..2.
REQ-017 SHALL drive oReady = 1 when count < 2 and iRst is low, else 0; oReady SHALL depend only on registered state.
REQ-018 SHALL accept (enqueue) on a rising edge where iValid && oReady.
REQ-019 SHALL consume but not store an accepted result with iAddr == 0 (register zero is hardwired); count is unchanged by it.
REQ-020 SHALL drive oEnWrite = 1 when count > 0; oAddrWrite/oDataWrite = head entry; all three 0 when count == 0.
REQ-021 SHALL retire (dequeue) the head on a rising edge where oEnWrite && !iHold.
REQ-022 SHALL present a result accepted at edge N on the write port in the cycle after edge N when the buffer was empty; minimum latency 1 cycle, no combinational input-to-write-port path.
REQ-023 SHALL keep count unchanged on simultaneous enqueue and retire, new entry becoming tail behind the remaining head.
REQ-024 SHALL hold all write-port outputs stable while iHold is asserted.
REQ-025 SHALL assert oHitK when any valid entry's addr equals iAddrLookK and iAddrLookK != 0; oFwdDataK = data of the youngest matching entry; no hit -> oHitK = 0, oFwdDataK = 0.
REQ-026 SHALL compute lookups combinationally from current contents only; a result being enqueued in the same cycle is not visible.
REQ-027 SHALL include the head entry being retired in the lookup in the cycle it is retired.
REQ-028 SHALL never overwrite an occupied entry; iValid while oReady = 0 has no effect.

Reset
REQ-029 SHALL on iRst asserted, asynchronously, set count = 0, entry valid bits cleared, oEnWrite = 0, oAddrWrite = 0, oDataWrite = 0, oHit0/1 = 0, oFwdData0/1 = 0, oReady = 0.
REQ-030 SHALL discard buffered entries on reset mid-operation, no write issued after assertion.
REQ-031 SHALL raise oReady = 1 in the first cycle after iRst deasserts.

Configuration
REQ-032 SHALL, with macro WB_FORWARD_EN defined, implement REQ-025..REQ-027 forwarding logic.
REQ-033 SHALL, with WB_FORWARD_EN undefined, tie oHit0/1 = 0 and oFwdData0/1 = 0, ports still present, and leave all other behaviour unchanged.

Verification
REQ-034 SHALL cover: reset, push addr 3 data 0xDEADBEEF with iHold = 0 -> next cycle oEnWrite = 1, oAddrWrite = 3, oDataWrite = 0xDEADBEEF; following cycle oEnWrite = 0.
REQ-035 SHALL cover: iHold = 1, push addr 1 data 0x11 then addr 2 data 0x22 -> oReady = 0 after the second push, third push ignored; release iHold -> writes to 1 then 2 in consecutive cycles.
REQ-036 SHALL cover: push addr 0 data 0xFFFF_FFFF -> accepted, oEnWrite stays 0, count stays 0.
REQ-037 SHALL cover: iHold = 1, push addr 5 data 0xA then addr 5 data 0xB, iAddrLook0 = 5, iAddrLook1 = 0 -> oHit0 = 1, oFwdData0 = 0xB, oHit1 = 0 (forwarding build); without WB_FORWARD_EN -> oHit0 = 0.
REQ-038 SHALL cover: count = 1, simultaneous push addr 7 data 0x77 and retire -> count stays 1, next write is addr 7 data 0x77.
REQ-039 SHALL cover: iRst pulse mid-cycle with count = 2 -> oEnWrite = 0 immediately, no writes after release, oReady = 1 one cycle after deassertion.
